imm_encoder: RTL and testbench

Reverse mapping of the immediate lookup path. Takes an 8-bit constant and produces the 5-bit immediate field that the decode-side immediate LUT expands back to that constant. Used by the program-load/assembler-assist path and by verification to check round-trip immediates. Values 0..15 encode directly; any other value is searched sequentially, one table entry per cycle.

---
 rtl/imm_encoder_if.sv | 35 +++
 rtl/imm_encoder.sv | 157 +++++++++++++++
 tb/tb_imm_encoder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/imm_encoder_if.sv
// ============================================================================
//  Module      : imm_encoder_if
//  Description : Request/response bundle for the immediate encoder.
//                Request side : in_valid, in_ready, datIn
//                Response side: out_valid, out_ready, code, found
//                slave  modport - the encoder
//                master modport - the requester / result consumer
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_encoder_if #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] datIn;
   logic              out_valid;
   logic              out_ready;
   logic [IDX_W:0]    code;
   logic              found;

   modport slave (
      input  in_valid, datIn, out_ready,
      output in_ready, out_valid, code, found
   );

   modport master (
      output in_valid, datIn, out_ready,
      input  in_ready, out_valid, code, found
   );
endinterface

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
//  Module      : imm_encoder
//  Description : Reverse of the decode-side immediate LUT. Maps an 8-bit
//                constant to the 5-bit immediate field that expands back to
//                it. Constants 0..15 encode directly as {0,value}; anything
//                else is searched through the 16-entry table, one entry per
//                cycle, lowest matching index first.
//  Ports       : Clk   - system clock, rising edge
//                Reset - asynchronous, active-high reset
//                bus   - imm_encoder_if.slave (request + response handshake)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder #(
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
) (
   input  wire logic     Clk,
   input  wire logic     Reset,
   imm_encoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   state_t            state_q,     state_d;
   logic [DATA_W-1:0] val_q,       val_d;
   logic [IDX_W-1:0]  idx_q,       idx_d;
   // hit_q/last_q carry the previous cycle's compare outcome, so the DONE
   // transition lands one cycle after the compare that produced it.
   logic              hit_q,       hit_d;
   logic              last_q,      last_d;
   logic [IDX_W:0]    pend_q,      pend_d;
   logic              in_ready_q,  in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic [IDX_W:0]    code_q,      code_d;
   logic              found_q,     found_d;
   logic [DATA_W-1:0] w_entry;

   function automatic logic [DATA_W-1:0] lut_f(input logic [IDX_W-1:0] i);
      logic [DATA_W-1:0] v;
      case (i)
         4'h0: v = 8'hF1;  4'h1: v = 8'h80;  4'h2: v = 8'h81;  4'h3: v = 8'hC8;
         4'h4: v = 8'h82;  4'h5: v = 8'h26;  4'h6: v = 8'hD7;  4'h7: v = 8'h40;
         4'h8: v = 8'h00;  4'h9: v = 8'hF5;  4'hA: v = 8'h80;  4'hB: v = 8'h4A;
         4'hC: v = 8'hF0;  4'hD: v = 8'hF9;  4'hE: v = 8'hFF;  default: v = 8'hF4;
      endcase
      return v;
   endfunction

   assign w_entry = lut_f(idx_q);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q     <= S_IDLE;
         val_q       <= '0;
         idx_q       <= '0;
         hit_q       <= 1'b0;
         last_q      <= 1'b0;
         pend_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         code_q      <= '0;
         found_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         val_q       <= val_d;
         idx_q       <= idx_d;
         hit_q       <= hit_d;
         last_q      <= last_d;
         pend_q      <= pend_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         code_q      <= code_d;
         found_q     <= found_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      val_d       = val_q;
      idx_d       = idx_q;
      hit_d       = hit_q;
      last_d      = last_q;
      pend_d      = pend_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      code_d      = code_q;
      found_d     = found_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               val_d      = bus.datIn;
               idx_d      = '0;
               last_d     = 1'b0;
               in_ready_d = 1'b0;
               state_d    = S_SCAN;
               // Direct values are pre-marked as hits so they leave SCAN on
               // the very next edge without touching the table; this also
               // keeps 0x00 from ever resolving to table index 8.
               if (bus.datIn[DATA_W-1:IDX_W] == '0) begin
                  hit_d  = 1'b1;
                  pend_d = {1'b0, bus.datIn[IDX_W-1:0]};
               end else begin
                  hit_d  = 1'b0;
                  pend_d = '0;
               end
            end
         end

         S_SCAN: begin
            if (hit_q || last_q) begin
               state_d     = S_DONE;
               out_valid_d = 1'b1;
               code_d      = hit_q ? pend_q : '0;
               found_d     = hit_q;
            end else begin
               if (w_entry == val_q) begin
                  hit_d  = 1'b1;
                  pend_d = {1'b1, idx_q};
               end
               last_d = (idx_q == LAST_IDX);
               idx_d  = idx_q + 1'b1;
            end
         end

         S_DONE: begin
            if (bus.out_ready) begin
               state_d     = S_IDLE;
               out_valid_d = 1'b0;
               code_d      = '0;
               found_d     = 1'b0;
               in_ready_d  = 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.code      = code_q;
   assign bus.found     = found_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Self-checking bench for imm_encoder. The driver pushes the
//                hand-computed expected code/found and the cycle on which
//                out_valid must first appear; a monitor pops and compares on
//                every rising out_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_encoder;

   typedef struct {
      logic [4:0] code;
      logic       found;
      int         due;
   } exp_t;

   logic Clk = 1'b0;
   logic Reset;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_fail = 0;
   exp_t sb[$];

   imm_encoder_if bus ();

   imm_encoder dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus.slave)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: compares each new result against the scoreboard head.
   logic prev_valid = 1'b0;
   always @(negedge Clk) begin
      if (bus.out_valid && !prev_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_out_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("code",    int'(bus.code),  int'(e.code));
            check("found",   int'(bus.found), int'(e.found));
            check("latency", cyc,             e.due);
         end
      end
      prev_valid = bus.out_valid;
   end

   task automatic wait_out();
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid === 1'b1) break;
         @(negedge Clk);
      end
      if (bus.out_valid !== 1'b1) check("out_valid_timeout", 0, 1);
   endtask

   // Issue one request; lat = edges from accept until out_valid is seen.
   task automatic do_req(input logic [7:0] d, input logic [4:0] c,
                         input logic f, input int lat, input bit push);
      @(negedge Clk);
      check("in_ready_idle", int'(bus.in_ready), 1);
      bus.datIn    = d;
      bus.in_valid = 1'b1;
      if (push) sb.push_back('{c, f, cyc + 1 + lat});
      @(posedge Clk);
      #1;
      bus.in_valid = 1'b0;
      check("in_ready_busy", int'(bus.in_ready), 0);
   endtask

   task automatic release_out();
      @(posedge Clk);
      #1;
      check("out_valid_drop", int'(bus.out_valid), 0);
      check("in_ready_back",  int'(bus.in_ready),  1);
      check("code_cleared",   int'(bus.code),      0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      Reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.datIn     = 8'h00;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge Clk);
      check("rst_in_ready",  int'(bus.in_ready),  1);
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_code",      int'(bus.code),      0);
      check("rst_found",     int'(bus.found),     0);
      Reset = 1'b0;

      // Direct path and table searches with out_ready held high.
      do_req(8'h07, 5'b00111, 1'b1, 1,  1'b1); wait_out(); release_out();
      do_req(8'h80, 5'b10001, 1'b1, 3,  1'b1); wait_out(); release_out();
      do_req(8'hF4, 5'b11111, 1'b1, 17, 1'b1); wait_out(); release_out();
      do_req(8'h55, 5'b00000, 1'b0, 17, 1'b1); wait_out(); release_out();
      do_req(8'h00, 5'b00000, 1'b1, 1,  1'b1); wait_out(); release_out();
      do_req(8'hF1, 5'b10000, 1'b1, 2,  1'b1); wait_out(); release_out();
      do_req(8'hFF, 5'b11110, 1'b1, 16, 1'b1); wait_out(); release_out();
      do_req(8'h0F, 5'b01111, 1'b1, 1,  1'b1); wait_out(); release_out();

      // Back-pressure: result must hold, new requests ignored.
      bus.out_ready = 1'b0;
      do_req(8'hC8, 5'b10011, 1'b1, 5, 1'b1);
      wait_out();
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.datIn    = 8'h07;
         @(negedge Clk);
         check("hold_out_valid", int'(bus.out_valid), 1);
         check("hold_code",      int'(bus.code),      5'b10011);
         check("hold_in_ready",  int'(bus.in_ready),  0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      release_out();

      // Reset mid-SCAN discards the pending result.
      do_req(8'hF4, 5'b00000, 1'b0, 0, 1'b0);
      repeat (6) @(negedge Clk);
      #2;
      Reset = 1'b1;
      #1;
      check("midrst_out_valid", int'(bus.out_valid), 0);
      check("midrst_in_ready",  int'(bus.in_ready),  1);
      check("midrst_code",      int'(bus.code),      0);
      check("midrst_found",     int'(bus.found),     0);
      @(negedge Clk);
      Reset = 1'b0;
      repeat (20) @(negedge Clk);
      check("midrst_no_valid", int'(bus.out_valid), 0);

      do_req(8'h26, 5'b10101, 1'b1, 7, 1'b1); wait_out(); release_out();

      repeat (3) @(negedge Clk);
      check("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
